// File: rtl/uart_rx_fifo_if.sv
// Read-side handshake of the UART receive FIFO: head word, its error tags and the pop request.
interface uart_rx_fifo_if #(
   parameter int DATA_W = 8
);
   logic              rd_en;
   logic              rd_valid;
   logic [DATA_W-1:0] rd_data;
   logic [2:0]        rd_flags;

   // Producer side (the receiver/FIFO).
   modport master (
      output rd_valid,
      output rd_data,
      output rd_flags,
      input  rd_en
   );

   // Consumer side (host logic reading characters).
   modport slave (
      input  rd_valid,
      input  rd_data,
      input  rd_flags,
      output rd_en
   );
endinterface

// File: rtl/uart_rx_fifo.sv
// Oversampling UART receiver with runtime baud/parity/stop configuration, per-character
// error tagging (break, parity, framing), a first-word-fall-through receive FIFO with
// sticky overrun, and line-idle / end-of-packet detection.
module uart_rx_fifo #(
   parameter int OVS       = 16,
   parameter int DIV_W     = 16,
   parameter int DATA_W    = 8,
   parameter int FIFO_AW   = 4,
   parameter int IDLE_BITS = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             rxd,
   input  logic [DIV_W-1:0] baud_div,
   input  logic [1:0]       parity_mode,
   input  logic             two_stop,
   uart_rx_fifo_if.master   rd,
   output logic [FIFO_AW:0] fifo_count,
   output logic             overrun,
   input  logic             clr_overrun,
   output logic             rx_idle,
   output logic             rx_eop
);
   localparam int OVS_W     = $clog2(OVS);
   localparam int BIT_W     = $clog2(DATA_W);
   localparam int GAP_MAX_I = IDLE_BITS * OVS;
   localparam int GAP_W     = $clog2(GAP_MAX_I + 1);
   localparam int DEPTH     = 2 ** FIFO_AW;
   localparam int CNT_W     = FIFO_AW + 1;
   localparam int WORD_W    = DATA_W + 3;

   localparam logic [OVS_W-1:0] MID_LO   = OVS_W'(OVS / 2 - 1);
   localparam logic [OVS_W-1:0] MID      = OVS_W'(OVS / 2);
   localparam logic [OVS_W-1:0] MID_HI   = OVS_W'(OVS / 2 + 1);
   localparam logic [OVS_W-1:0] LAST     = OVS_W'(OVS - 1);
   localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);
   localparam logic [GAP_W-1:0] GAP_MAX  = GAP_W'(GAP_MAX_I);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2} state_t;

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

   // mode 01 = even, 10 = odd, anything else has no parity bit and never flags.
   function automatic logic parity_err(input logic [DATA_W-1:0] data, input logic pbit,
                                       input logic [1:0] mode);
      logic ones_odd;
      ones_odd = (^data) ^ pbit;
      case (mode)
         2'b01:   return ones_odd;
         2'b10:   return ~ones_odd;
         default: return 1'b0;
      endcase
   endfunction

   state_t              state_q, state_d;
   logic [1:0]          sync_q, sync_d;
   logic [DIV_W-1:0]    tick_cnt_q, tick_cnt_d;
   logic [OVS_W-1:0]    ovs_cnt_q, ovs_cnt_d;
   logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
   logic [1:0]          samp_q, samp_d;
   logic [DATA_W-1:0]   shreg_q, shreg_d;
   logic                pbit_q, pbit_d;
   logic                ferr_q, ferr_d;
   logic [1:0]          par_mode_q, par_mode_d;
   logic                two_stop_q, two_stop_d;
   logic                armed_q, armed_d;
   logic                done_once_q, done_once_d;
   logic                push_q, push_d;
   logic [WORD_W-1:0]   push_word_q, push_word_d;
   logic [GAP_W-1:0]    gap_q, gap_d;
   logic                rx_idle_q, rx_idle_d;
   logic                rx_eop_q, rx_eop_d;
   logic [FIFO_AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]    count_q, count_d;
   logic                overrun_q, overrun_d;
   logic [WORD_W-1:0]   mem_q [DEPTH];

   logic rxd_s, tick_s, mid_s, end_s, maj_s, par_en_s, finish_s, ferr_fin_s, brk_s, perr_s;
   logic pop_s, wr_ok_s;

   // Receiver datapath and frame sequencing: next-state for every receive-side register.
   always_comb begin
      rxd_s      = sync_q[1];
      // >= rather than == keeps the tick alive if baud_div is lowered below the running count.
      tick_s     = (tick_cnt_q >= baud_div);
      mid_s      = tick_s & (ovs_cnt_q == MID_HI);
      end_s      = tick_s & (ovs_cnt_q == LAST);
      maj_s      = maj3(samp_q[0], samp_q[1], rxd_s);
      par_en_s   = (par_mode_q == 2'b01) | (par_mode_q == 2'b10);
      finish_s   = 1'b0;
      ferr_fin_s = ferr_q;
      perr_s     = parity_err(shreg_q, pbit_q, par_mode_q);

      sync_d      = {sync_q[0], rxd};
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      shreg_d     = shreg_q;
      pbit_d      = pbit_q;
      ferr_d      = ferr_q;
      par_mode_d  = par_mode_q;
      two_stop_d  = two_stop_q;
      done_once_d = done_once_q;
      push_d      = 1'b0;
      push_word_d = push_word_q;

      if (tick_s) begin
         tick_cnt_d = {DIV_W{1'b0}};
         ovs_cnt_d  = (ovs_cnt_q == LAST) ? {OVS_W{1'b0}} : ovs_cnt_q + OVS_W'(1);
      end else begin
         tick_cnt_d = tick_cnt_q + DIV_W'(1);
         ovs_cnt_d  = ovs_cnt_q;
      end

      if (tick_s && (ovs_cnt_q == MID_LO)) begin
         samp_d = {samp_q[1], rxd_s};
      end else if (tick_s && (ovs_cnt_q == MID)) begin
         samp_d = {rxd_s, samp_q[0]};
      end else begin
         samp_d = samp_q;
      end

      if (rxd_s) begin
         armed_d = 1'b1;
      end else begin
         armed_d = armed_q;
      end

      case (state_q)
         S_IDLE: begin
            if (!rxd_s && armed_q) begin
               state_d    = S_START;
               tick_cnt_d = {DIV_W{1'b0}};
               ovs_cnt_d  = {OVS_W{1'b0}};
               bit_cnt_d  = {BIT_W{1'b0}};
               pbit_d     = 1'b0;
               ferr_d     = 1'b0;
               par_mode_d = parity_mode;
               two_stop_d = two_stop;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_START: begin
            if (mid_s && maj_s) begin
               state_d = S_IDLE;
            end else if (end_s) begin
               state_d = S_DATA;
            end else begin
               state_d = S_START;
            end
         end
         S_DATA: begin
            if (mid_s) begin
               shreg_d = {maj_s, shreg_q[DATA_W-1:1]};
            end else begin
               shreg_d = shreg_q;
            end
            if (end_s && (bit_cnt_q == LAST_BIT)) begin
               bit_cnt_d = {BIT_W{1'b0}};
               state_d   = par_en_s ? S_PARITY : S_STOP1;
            end else if (end_s) begin
               bit_cnt_d = bit_cnt_q + BIT_W'(1);
            end else begin
               bit_cnt_d = bit_cnt_q;
            end
         end
         S_PARITY: begin
            if (mid_s) begin
               pbit_d = maj_s;
            end else if (end_s) begin
               state_d = S_STOP1;
            end else begin
               pbit_d = pbit_q;
            end
         end
         S_STOP1: begin
            if (mid_s) begin
               ferr_d     = ~maj_s;
               finish_s   = ~two_stop_q;
               ferr_fin_s = ~maj_s;
            end else if (end_s && two_stop_q) begin
               state_d = S_STOP2;
            end else begin
               state_d = S_STOP1;
            end
         end
         S_STOP2: begin
            if (mid_s) begin
               finish_s   = 1'b1;
               ferr_fin_s = ferr_q | ~maj_s;
            end else begin
               state_d = S_STOP2;
            end
         end
         default: state_d = S_IDLE;
      endcase

      brk_s = ferr_fin_s & (shreg_q == {DATA_W{1'b0}}) & ~(par_en_s & pbit_q);

      // Leaving at the stop mid-sample lets the next start edge be caught early; a framing
      // error disarms so a line stuck low produces one break entry only.
      if (finish_s) begin
         state_d     = S_IDLE;
         push_d      = 1'b1;
         push_word_d = {brk_s, perr_s, ferr_fin_s, shreg_q};
         done_once_d = 1'b1;
         armed_d     = ferr_fin_s ? 1'b0 : (armed_q | rxd_s);
      end else begin
         push_word_d = push_word_q;
      end

      if (state_q != S_IDLE) begin
         gap_d = {GAP_W{1'b0}};
      end else if (tick_s && (gap_q != GAP_MAX)) begin
         gap_d = gap_q + GAP_W'(1);
      end else begin
         gap_d = gap_q;
      end
      rx_idle_d = done_once_q & (gap_q == GAP_MAX);
      rx_eop_d  = rx_idle_d & ~rx_idle_q;
   end

   // FIFO bookkeeping: a pop on a full FIFO frees the slot for a same-cycle push.
   always_comb begin
      pop_s   = rd.rd_en & (count_q != {CNT_W{1'b0}});
      wr_ok_s = push_q & ((count_q != FULL_CNT) | pop_s);
      wr_ptr_d = wr_ok_s ? wr_ptr_q + FIFO_AW'(1) : wr_ptr_q;
      rd_ptr_d = pop_s ? rd_ptr_q + FIFO_AW'(1) : rd_ptr_q;
      case ({wr_ok_s, pop_s})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
      if (push_q && !wr_ok_s) begin
         overrun_d = 1'b1;
      end else if (clr_overrun) begin
         overrun_d = 1'b0;
      end else begin
         overrun_d = overrun_q;
      end
   end

   // State register with synchronous reset; synchroniser resets high so no phantom start.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         sync_q      <= 2'b11;
         tick_cnt_q  <= {DIV_W{1'b0}};
         ovs_cnt_q   <= {OVS_W{1'b0}};
         bit_cnt_q   <= {BIT_W{1'b0}};
         samp_q      <= 2'b11;
         shreg_q     <= {DATA_W{1'b0}};
         pbit_q      <= 1'b0;
         ferr_q      <= 1'b0;
         par_mode_q  <= 2'b00;
         two_stop_q  <= 1'b0;
         armed_q     <= 1'b0;
         done_once_q <= 1'b0;
         push_q      <= 1'b0;
         push_word_q <= {WORD_W{1'b0}};
         gap_q       <= {GAP_W{1'b0}};
         rx_idle_q   <= 1'b0;
         rx_eop_q    <= 1'b0;
         wr_ptr_q    <= {FIFO_AW{1'b0}};
         rd_ptr_q    <= {FIFO_AW{1'b0}};
         count_q     <= {CNT_W{1'b0}};
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         sync_q      <= sync_d;
         tick_cnt_q  <= tick_cnt_d;
         ovs_cnt_q   <= ovs_cnt_d;
         bit_cnt_q   <= bit_cnt_d;
         samp_q      <= samp_d;
         shreg_q     <= shreg_d;
         pbit_q      <= pbit_d;
         ferr_q      <= ferr_d;
         par_mode_q  <= par_mode_d;
         two_stop_q  <= two_stop_d;
         armed_q     <= armed_d;
         done_once_q <= done_once_d;
         push_q      <= push_d;
         push_word_q <= push_word_d;
         gap_q       <= gap_d;
         rx_idle_q   <= rx_idle_d;
         rx_eop_q    <= rx_eop_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         overrun_q   <= overrun_d;
      end
   end

   // FIFO storage; contents are don't-care while empty, so no reset.
   always_ff @(posedge clk) begin
      if (wr_ok_s) begin
         mem_q[wr_ptr_q] <= push_word_q;
      end
   end

   assign rd.rd_valid = (count_q != {CNT_W{1'b0}});
   assign rd.rd_data  = mem_q[rd_ptr_q][DATA_W-1:0];
   assign rd.rd_flags = mem_q[rd_ptr_q][WORD_W-1:DATA_W];
   assign fifo_count  = count_q;
   assign overrun     = overrun_q;
   assign rx_idle     = rx_idle_q;
   assign rx_eop      = rx_eop_q;
endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Parametrised successor to the team's fixed 8N1 UART receiver, for the OpenADC host/serial path.
- Adds a runtime baud divisor, configurable oversampling and data width, and runtime parity (none/even/odd) and 1/2 stop-bit selection.
- Adds per-character error tagging (framing, parity, break) and an on-chip receive FIFO with sticky overrun.
- Keeps the idle / end-of-packet gap detection.

Parameters:
- OVS, 16, oversample ticks per bit; even, 8..32.
- DIV_W, 16, width of baud_div.
- DATA_W, 8, data bits per character, 5..9, LSB first.
- FIFO_AW, 4, FIFO address width; depth = 2**FIFO_AW.
- IDLE_BITS, 2, bit times of line-idle before rx_idle asserts.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- reset  in  1  synchronous, active-high.
- rxd  in  1  asynchronous serial input, idle high.
- baud_div  in  DIV_W  oversample tick period minus 1, in clk cycles.
- parity_mode  in  2  00 none, 01 even, 10 odd, 11 treated as none.
- two_stop  in  1  1 = two stop bits expected.
- rd_en  in  1  pop FIFO head when rd_valid.
- rd_valid  out  1  FIFO non-empty; head presented on rd_data and rd_flags.
- rd_data  out  DATA_W  head character.
- rd_flags  out  3  {break, parity_err, frame_err} of head.
- fifo_count  out  FIFO_AW+1  occupancy.
- overrun  out  1  sticky; set when a character is dropped on a full FIFO.
- clr_overrun  in  1  one-cycle clear of overrun.
- rx_idle  out  1  line idle for IDLE_BITS bit times.
- rx_eop  out  1  one-cycle pulse on the rising edge of rx_idle.

Behaviour:
- Reset values: rd_valid 0, fifo_count 0, overrun 0, rx_idle 0, rx_eop 0. rd_data and rd_flags are don't-care while rd_valid is 0.
- Synchroniser: rxd passes through 2 flops, both reset to 1, so no phantom start bit after reset.
- Tick generator: counter 0..baud_div, tick when counter == baud_div, then returns to 0; tick period is baud_div+1 clocks. baud_div is used live. The counter free-runs in IDLE and restarts at 0 on start-bit detection.
- Bit timing: each bit lasts OVS ticks, tick index 0..OVS-1 within the bit. The bit value is the majority of the synced samples at ticks OVS/2-1, OVS/2 and OVS/2+1.
- States and transitions:
  - IDLE: synced rxd == 0 and armed -> START. Latch parity_mode and two_stop at this point.
  - START: majority 1 -> IDLE (glitch rejected, nothing pushed). Else at tick OVS-1 -> DATA.
  - DATA: DATA_W bits, shift in LSB first. After the last bit -> PARITY if parity enabled, else STOP1.
  - PARITY: parity_err = (xor(data) ^ pbit) != 0 for even; == 0 for odd.
  - STOP1: decided at its mid-sample (tick OVS/2+1). frame_err = 0 if majority 1. -> STOP2 if two_stop, else finish.
  - STOP2: frame_err also set if its majority is 0. Finish.
  - Finish: return to IDLE on the mid-sample cycle, so the next start bit is caught early.
- Arming: IDLE is armed only after synced rxd has been seen 1. Any frame with frame_err disarms it, so a held-low line does not retrigger.
- break = frame_err & (data == 0) & (pbit == 0 or no parity).
- Push: the cycle after the final mid-sample, push {flags, data}. rd_valid rises the following cycle when the FIFO was empty (first-word fall-through).
- FIFO full on push: drop the character and set overrun.
- Simultaneous rd_en and push on a full FIFO: pop first, so the push succeeds and there is no overrun.
- rd_en with rd_valid 0 is ignored. Simultaneous push and pop leaves count unchanged.
- clr_overrun in the same cycle as a new overrun event: overrun stays 1.
- Idle: gap counter resets whenever state != IDLE and counts ticks in IDLE. rx_idle = gap count reached IDLE_BITS*OVS, saturating. rx_eop pulses on the cycle rx_idle goes 0->1. Neither is asserted after reset until a first frame has completed.
- Reset mid-frame: the frame is discarded, FIFO emptied, state IDLE, armed once rxd is seen high.

Test Plan:
- OVS=16, baud_div=0 (16 clk/bit), parity none, one stop; send 0x55 -> one entry: rd_data=0x55, rd_flags=000, rd_valid rises 2 clocks after the stop mid-sample.
- Even parity; send 0xA3 with parity bit 0 (correct is 0) then 0xA3 with parity bit 1 -> flags 000 then 010, data 0xA3 both.
- two_stop=1; send 0x3C with second stop bit low -> flags 001. Then hold rxd high 1 bit and send 0x12 -> 0x12 with flags 000.
- Hold rxd low for 12 bit times, then high -> exactly one entry, data 0x00, flags 101, no further entries.
- FIFO_AW=4; send 17 chars 0x00..0x10 without reading -> count 16, overrun=1, head 0x00, 0x10 absent. clr_overrun -> overrun 0.
- rxd low pulse of 4 clocks -> no entry. After any frame, line high 32 bit ticks -> rx_eop single pulse, rx_idle stays 1. Reset asserted mid-DATA -> count 0, no entry.
